spi_cs_sequencer: RTL and testbench
===================================

// Module: spi_cs_sequencer
// PURPOSE
//  Controller in front of SPI_Master. Frames multi-byte SPI transactions under one chip-select.
//  Latches byte count and target slave, then drives the selected CS_n low with setup, hold and
//  inter-transaction idle timing. Feeds bytes to the master one at a time; returns RX bytes.
//  The SPI clock and data stay in SPI_Master; this block owns CS_n and transaction sequencing.
// PARAMETERS
//  NUM_CS          1  number of chip-select lines / slaves (>=1)
//  MAX_BYTES_PER_CS 8 max bytes per transaction; count width CW = $clog2(MAX_BYTES_PER_CS+1)
//  CS_SETUP_CLKS   2  i_Clk cycles CS_n low before first byte is issued (>=1)
//  CS_HOLD_CLKS    2  i_Clk cycles CS_n held low after last byte's RX_DV (>=1)
//  CS_IDLE_CLKS    2  i_Clk cycles CS_n high before next transaction may start (>=1)
// PORTS
//  i_Clk         in   1        system clock, same clock as SPI_Master
//  i_Rst_L       in   1        asynchronous, active-low reset
//  i_TX_Count    in   CW       bytes in transaction; sampled only with first-byte i_TX_DV
//  i_CS_Sel      in   clog2(NUM_CS) (min 1)  slave index; sampled only with first-byte i_TX_DV
//  i_TX_Byte     in   8        byte to send
//  i_TX_DV       in   1        byte valid; accepted only when o_TX_Ready=1
//  o_TX_Ready    out  1        block accepts i_TX_DV this cycle
//  o_RX_DV       out  1        1-cycle pulse, received byte valid
//  o_RX_Byte     out  8        received byte
//  o_M_TX_Byte   out  8        to SPI_Master i_TX_Byte
//  o_M_TX_DV     out  1        to SPI_Master i_TX_DV (1-cycle pulse)
//  i_M_TX_Ready  in   1        from SPI_Master o_TX_Ready
//  i_M_RX_DV     in   1        from SPI_Master o_RX_DV
//  i_M_RX_Byte   in   8        from SPI_Master o_RX_Byte
//  o_SPI_CS_n    out  NUM_CS   active-low chip selects
// BEHAVIOUR
//  Reset (async, any state): o_SPI_CS_n all 1s; o_TX_Ready, o_RX_DV, o_M_TX_DV = 0.
//   o_RX_Byte, o_M_TX_Byte = 8'h00; state IDLE; counters cleared.
//  All outputs are registered. o_TX_Ready rises the first cycle after reset release.
//  FSM states: IDLE, SETUP, ISSUE, BUSY, NEXT, HOLD, GAP.
//  IDLE: o_TX_Ready=1. On i_TX_DV: latch byte, remaining count and sel.
//   Count 0 is treated as 1. Go to SETUP; CS_n[sel] goes low the next cycle.
//  SETUP: hold for CS_SETUP_CLKS cycles, then go to ISSUE.
//  ISSUE: when i_M_TX_Ready=1, pulse o_M_TX_DV with the latched byte and decrement remaining.
//   Then go to BUSY.
//  BUSY: wait for i_M_RX_DV. If remaining>0, go to NEXT; otherwise go to HOLD.
//  NEXT: o_TX_Ready=1 while i_M_TX_Ready=1. On i_TX_DV: latch byte, go to ISSUE.
//   The byte reaches o_M_TX_DV 1 cycle later. i_TX_Count and i_CS_Sel are ignored here.
//  HOLD: CS_n stays low for CS_HOLD_CLKS cycles, then all CS_n go high; go to GAP.
//  GAP: CS_n high for CS_IDLE_CLKS cycles with o_TX_Ready=0, then go to IDLE.
//  o_TX_Ready drops the cycle after an accepted i_TX_DV.
//   i_TX_DV while o_TX_Ready=0 is ignored: no state, byte or CS change.
//  RX path: o_RX_DV / o_RX_Byte are i_M_RX_DV / i_M_RX_Byte delayed 1 cycle, in every state.
//  At most one CS_n bit is low at any time. CS_n never changes between first and last byte.
//  i_CS_Sel >= NUM_CS: the transaction runs fully with timing intact; no CS_n line asserts.
//  Remaining counter saturates at 0; no wrap-around.
// CONFIGURATION
//  SPI_CS_SEQ_ERR_EN defined: adds output o_Err (1 bit, reset 0).
//   o_Err gives a 1-cycle pulse, 1 cycle after any ignored i_TX_DV.
//   It also pulses 1 cycle after a first-byte accept with i_CS_Sel >= NUM_CS.
//  Not defined: no o_Err port. Ignored pulses and bad selects are silent; behaviour otherwise identical.
// TESTING
//  Setup for all tests: SPI_Master mode 0, CLKS_PER_HALF_BIT=2, MISO looped to MOSI, defaults.
//  T1 Count=1, Sel=0, byte 8'hA5 -> CS_n[0] low 1 cycle after DV.
//     o_M_TX_DV 2 cycles later; o_RX_Byte=8'hA5.
//     CS_n[0] high 2 cycles after o_RX_DV arrives at the block.
//  T2 Count=3, bytes 11,22,33 fed on o_TX_Ready -> CS_n[0] low continuously.
//     3 o_RX_DV pulses with 11,22,33; exactly 3 o_M_TX_DV pulses.
//  T3 Two back-to-back Count=1 transactions -> CS_n high >= 2 cycles between them.
//     o_TX_Ready=0 during the gap.
//  T4 i_TX_DV pulsed during BUSY with 8'hFF -> ignored; MOSI stream unchanged.
//     With SPI_CS_SEQ_ERR_EN, o_Err pulses once.
//  T5 i_Rst_L low mid-byte of a Count=2 transaction -> CS_n=all 1s immediately; outputs at reset values.
//     After release, o_TX_Ready=1 next cycle and a new transaction completes normally.
//  T6 Count=0 -> exactly 1 byte sent.
//     NUM_CS=2 with Sel=2 -> no CS_n low, 1 byte sent, o_Err pulse when enabled.

Source files
------------

// File: rtl/spi_cs_sequencer.sv
// Chip-select and transaction sequencer placed in front of SPI_Master.
// Optional o_Err port is enabled with `define SPI_CS_SEQ_ERR_EN.
module spi_cs_sequencer #(
  parameter int NUM_CS           = 1,
  parameter int MAX_BYTES_PER_CS = 8,
  parameter int CS_SETUP_CLKS    = 2,
  parameter int CS_HOLD_CLKS     = 2,
  parameter int CS_IDLE_CLKS     = 2,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1),
  localparam int SW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [CW-1:0]     i_TX_Count,
  input  logic [SW-1:0]     i_CS_Sel,
  input  logic [7:0]        i_TX_Byte,
  input  logic              i_TX_DV,
  output logic              o_TX_Ready,
  output logic              o_RX_DV,
  output logic [7:0]        o_RX_Byte,
  output logic [7:0]        o_M_TX_Byte,
  output logic              o_M_TX_DV,
  input  logic              i_M_TX_Ready,
  input  logic              i_M_RX_DV,
  input  logic [7:0]        i_M_RX_Byte,
`ifdef SPI_CS_SEQ_ERR_EN
  output logic              o_Err,
`endif
  output logic [NUM_CS-1:0] o_SPI_CS_n
);

  localparam int TW = 16;

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, BUSY, NEXT, HOLD, GAP} state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [CW-1:0]     rem_cnt, rem_nx;
  logic [7:0]        tx_byte_r, byte_nx;
  logic              ready_nx, m_dv_nx;
  logic [7:0]        m_byte_nx;
  logic [NUM_CS-1:0] cs_nx, sel_dec;
  logic              accept;
`ifdef SPI_CS_SEQ_ERR_EN
  logic              err_nx;
  logic              bad_sel;
  assign bad_sel = (32'(i_CS_Sel) >= NUM_CS);
`endif

  assign accept = i_TX_DV && o_TX_Ready;

  // An out-of-range select decodes to no active line at all.
  always_comb begin
    sel_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (i_CS_Sel == SW'(i)) sel_dec[i] = 1'b0;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    rem_nx    = rem_cnt;
    byte_nx   = tx_byte_r;
    ready_nx  = 1'b0;
    m_dv_nx   = 1'b0;
    m_byte_nx = o_M_TX_Byte;
    cs_nx     = o_SPI_CS_n;
`ifdef SPI_CS_SEQ_ERR_EN
    err_nx    = i_TX_DV && !o_TX_Ready;
`endif
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (accept) begin
          byte_nx  = i_TX_Byte;
          rem_nx   = (i_TX_Count == '0) ? CW'(1) : i_TX_Count;
          cs_nx    = sel_dec;
          timer_nx = '0;
          ready_nx = 1'b0;
          state_nx = (CS_SETUP_CLKS > 1) ? SETUP : ISSUE;
`ifdef SPI_CS_SEQ_ERR_EN
          err_nx   = bad_sel;
`endif
        end
      end
      // The ISSUE cycle itself is the final setup cycle, so SETUP lasts one less.
      SETUP: begin
        if (timer == TW'(CS_SETUP_CLKS - 2)) begin
          timer_nx = '0;
          state_nx = ISSUE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      ISSUE: begin
        if (i_M_TX_Ready) begin
          m_dv_nx   = 1'b1;
          m_byte_nx = tx_byte_r;
          rem_nx    = (rem_cnt != '0) ? rem_cnt - CW'(1) : '0;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        if (i_M_RX_DV) begin
          if (rem_cnt != '0) begin
            state_nx = NEXT;
            ready_nx = i_M_TX_Ready;
          end else begin
            timer_nx = '0;
            state_nx = HOLD;
          end
        end
      end
      NEXT: begin
        ready_nx = i_M_TX_Ready;
        if (accept) begin
          byte_nx  = i_TX_Byte;
          ready_nx = 1'b0;
          state_nx = ISSUE;
        end
      end
      HOLD: begin
        if (timer == TW'(CS_HOLD_CLKS - 1)) begin
          cs_nx    = '1;
          timer_nx = '0;
          state_nx = GAP;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      GAP: begin
        if (timer == TW'(CS_IDLE_CLKS - 1)) begin
          timer_nx = '0;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      timer       <= '0;
      rem_cnt     <= '0;
      tx_byte_r   <= '0;
      o_TX_Ready  <= 1'b0;
      o_M_TX_DV   <= 1'b0;
      o_M_TX_Byte <= 8'h00;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= 8'h00;
      o_SPI_CS_n  <= '1;
`ifdef SPI_CS_SEQ_ERR_EN
      o_Err       <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      rem_cnt     <= rem_nx;
      tx_byte_r   <= byte_nx;
      o_TX_Ready  <= ready_nx;
      o_M_TX_DV   <= m_dv_nx;
      o_M_TX_Byte <= m_byte_nx;
      o_RX_DV     <= i_M_RX_DV;
      o_RX_Byte   <= i_M_RX_Byte;
      o_SPI_CS_n  <= cs_nx;
`ifdef SPI_CS_SEQ_ERR_EN
      o_Err       <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Self-checking bench for spi_cs_sequencer with a behavioural loopback SPI_Master model.
module tb_spi_cs_sequencer;
  localparam int NUM_CS = 3;
  localparam int CW     = 4;
  localparam int SW     = 2;

  logic              clk = 1'b0;
  logic              rst_l = 1'b1;
  logic [CW-1:0]     tx_count = '0;
  logic [SW-1:0]     cs_sel = '0;
  logic [7:0]        tx_byte = '0;
  logic              tx_dv = 1'b0;
  logic              tx_ready, rx_dv, m_tx_dv;
  logic [7:0]        rx_byte, m_tx_byte;
  logic              m_ready, m_rx_dv;
  logic [7:0]        m_rx_byte, m_lat_byte;
  logic [3:0]        m_cnt;
  logic [NUM_CS-1:0] cs_n;
`ifdef SPI_CS_SEQ_ERR_EN
  logic              err;
  int                err_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        mosi_q[$];
  logic [7:0]        rx_q[$];
  int                cs_changes = 0;
  int                multi_low = 0;
  int                cs_low[NUM_CS];
  logic [NUM_CS-1:0] cs_prev = '1;

  always #5 clk = ~clk;

  spi_cs_sequencer #(.NUM_CS(NUM_CS)) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_l),
    .i_TX_Count(tx_count),
    .i_CS_Sel(cs_sel),
    .i_TX_Byte(tx_byte),
    .i_TX_DV(tx_dv),
    .o_TX_Ready(tx_ready),
    .o_RX_DV(rx_dv),
    .o_RX_Byte(rx_byte),
    .o_M_TX_Byte(m_tx_byte),
    .o_M_TX_DV(m_tx_dv),
    .i_M_TX_Ready(m_ready),
    .i_M_RX_DV(m_rx_dv),
    .i_M_RX_Byte(m_rx_byte),
`ifdef SPI_CS_SEQ_ERR_EN
    .o_Err(err),
`endif
    .o_SPI_CS_n(cs_n)
  );

  // Loopback master: busy for a few cycles after each byte, then returns it.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_ready    <= 1'b1;
      m_rx_dv    <= 1'b0;
      m_rx_byte  <= 8'h00;
      m_cnt      <= '0;
      m_lat_byte <= 8'h00;
    end else begin
      m_rx_dv <= 1'b0;
      if (m_tx_dv) begin
        m_ready    <= 1'b0;
        m_cnt      <= 4'd4;
        m_lat_byte <= m_tx_byte;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd1) begin
          m_rx_dv   <= 1'b1;
          m_rx_byte <= m_lat_byte;
          m_ready   <= 1'b1;
        end
      end
    end
  end

  initial for (int i = 0; i < NUM_CS; i++) cs_low[i] = 0;

  always @(negedge clk) begin
    if (m_tx_dv) mosi_q.push_back(m_tx_byte);
    if (rx_dv) rx_q.push_back(rx_byte);
    if (cs_n != cs_prev) cs_changes <= cs_changes + 1;
    cs_prev <= cs_n;
    for (int i = 0; i < NUM_CS; i++) if (!cs_n[i]) cs_low[i] <= cs_low[i] + 1;
    if ($countones(~cs_n) > 1) multi_low <= multi_low + 1;
`ifdef SPI_CS_SEQ_ERR_EN
    if (err) err_cnt <= err_cnt + 1;
`endif
  end

  typedef struct {
    logic [CW-1:0]     count;
    logic [SW-1:0]     sel;
    logic [23:0]       bytes;
    int                nbytes;
    logic [NUM_CS-1:0] exp_mask;
    int                exp_changes;
    int                exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting", name);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!tx_ready && n < 200) begin tick(); n++; end
    if (!tx_ready) timeoutFail(name);
  endtask

  task automatic waitRx(input string name);
    int n = 0;
    while (!rx_dv && n < 200) begin tick(); n++; end
    if (!rx_dv) timeoutFail(name);
  endtask

  task automatic waitMDv(input string name);
    int n = 0;
    while (!m_tx_dv && n < 200) begin tick(); n++; end
    if (!m_tx_dv) timeoutFail(name);
  endtask

  task automatic applyStimulus(input logic [CW-1:0] cnt, input logic [SW-1:0] sel, input logic [7:0] b);
    waitReady("ready_before_dv");
    tx_count = cnt;
    cs_sel   = sel;
    tx_byte  = b;
    tx_dv    = 1'b1;
    tick();
    tx_dv    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int m0, x0, c0, gap;
    int low0[NUM_CS];
    logic [NUM_CS-1:0] mask;
`ifdef SPI_CS_SEQ_ERR_EN
    int e0;
`endif

    vecs[0] = '{4'd3, 2'd0, 24'h332211, 3, 3'b001, 2, 0};
    vecs[1] = '{4'd0, 2'd0, 24'h000077, 1, 3'b001, 2, 0};
    vecs[2] = '{4'd2, 2'd1, 24'h00C35A, 2, 3'b010, 2, 0};
    vecs[3] = '{4'd1, 2'd2, 24'h0000E7, 1, 3'b100, 2, 0};
    vecs[4] = '{4'd1, 2'd3, 24'h00009C, 1, 3'b000, 0, 1};

    #2 rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cs_n", 32'(cs_n), 32'h7);
    checkOutput("reset_tx_ready", 32'(tx_ready), 0);
    checkOutput("reset_m_tx_dv", 32'(m_tx_dv), 0);
    checkOutput("reset_rx_dv", 32'(rx_dv), 0);
    checkOutput("reset_m_tx_byte", 32'(m_tx_byte), 0);
    rst_l = 1'b1;
    tick();
    checkOutput("ready_after_reset", 32'(tx_ready), 1);

    // T1: single byte, cycle-exact CS framing
    tx_count = 4'd1; cs_sel = 2'd0; tx_byte = 8'hA5; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
    checkOutput("t1_cs_low", 32'(cs_n), 32'h6);
    checkOutput("t1_ready_drop", 32'(tx_ready), 0);
    tick();
    checkOutput("t1_setup_no_dv", 32'(m_tx_dv), 0);
    tick();
    checkOutput("t1_m_tx_dv", 32'(m_tx_dv), 1);
    checkOutput("t1_m_tx_byte", 32'(m_tx_byte), 32'hA5);
    tick();
    checkOutput("t1_m_tx_dv_pulse", 32'(m_tx_dv), 0);
    waitRx("t1_rx");
    checkOutput("t1_rx_byte", 32'(rx_byte), 32'hA5);
    checkOutput("t1_cs_hold0", 32'(cs_n), 32'h6);
    tick();
    checkOutput("t1_cs_hold1", 32'(cs_n), 32'h6);
    checkOutput("t1_rx_dv_pulse", 32'(rx_dv), 0);
    tick();
    checkOutput("t1_cs_release", 32'(cs_n), 32'h7);
    checkOutput("t1_gap_ready", 32'(tx_ready), 0);
    waitReady("t1_idle");

    // T3: back-to-back transactions, gap timing
    applyStimulus(4'd1, 2'd0, 8'h12);
    gap = 0;
    while (cs_n != 3'b111 && gap < 200) begin tick(); gap++; end
    gap = 0;
    while (!tx_ready && gap < 50) begin
      checkOutput("t3_gap_cs_high", 32'(cs_n), 32'h7);
      tick();
      gap++;
    end
    checkOutput("t3_gap_len", gap, 2);
    tx_count = 4'd1; cs_sel = 2'd0; tx_byte = 8'h34; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
    checkOutput("t3_second_cs_low", 32'(cs_n), 32'h6);
    waitRx("t3_rx");
    checkOutput("t3_rx_byte", 32'(rx_byte), 32'h34);
    waitReady("t3_idle");

    // T4: i_TX_DV during BUSY is ignored
    m0 = mosi_q.size();
`ifdef SPI_CS_SEQ_ERR_EN
    e0 = err_cnt;
`endif
    applyStimulus(4'd1, 2'd0, 8'h3C);
    waitMDv("t4_m_dv");
    tick();
    tx_count = 4'd3; cs_sel = 2'd1; tx_byte = 8'hFF; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
    checkOutput("t4_ignored_ready", 32'(tx_ready), 0);
    checkOutput("t4_cs_unchanged", 32'(cs_n), 32'h6);
`ifdef SPI_CS_SEQ_ERR_EN
    checkOutput("t4_err_pulse", 32'(err), 1);
    tick();
    checkOutput("t4_err_clear", 32'(err), 0);
`endif
    waitRx("t4_rx");
    checkOutput("t4_rx_byte", 32'(rx_byte), 32'h3C);
    waitReady("t4_idle");
    checkOutput("t4_mosi_count", mosi_q.size() - m0, 1);
    checkOutput("t4_mosi_byte", 32'(mosi_q[m0]), 32'h3C);
`ifdef SPI_CS_SEQ_ERR_EN
    checkOutput("t4_err_count", err_cnt - e0, 1);
`endif

    // Table: multi-byte, count 0, each select and an out-of-range select
    for (int r = 0; r < 5; r++) begin
      m0 = mosi_q.size();
      x0 = rx_q.size();
      c0 = cs_changes;
      for (int i = 0; i < NUM_CS; i++) low0[i] = cs_low[i];
`ifdef SPI_CS_SEQ_ERR_EN
      e0 = err_cnt;
`endif
      applyStimulus(vecs[r].count, vecs[r].sel, vecs[r].bytes[7:0]);
      for (int k = 1; k < vecs[r].nbytes; k++)
        applyStimulus(4'd7, 2'd2, vecs[r].bytes[8*k +: 8]);
      waitReady($sformatf("v%0d_idle", r));
      checkOutput($sformatf("v%0d_mosi_count", r), mosi_q.size() - m0, vecs[r].nbytes);
      checkOutput($sformatf("v%0d_rx_count", r), rx_q.size() - x0, vecs[r].nbytes);
      for (int k = 0; k < vecs[r].nbytes; k++) begin
        if (m0 + k < mosi_q.size())
          checkOutput($sformatf("v%0d_mosi_%0d", r, k), 32'(mosi_q[m0+k]), 32'(vecs[r].bytes[8*k +: 8]));
        if (x0 + k < rx_q.size())
          checkOutput($sformatf("v%0d_rx_%0d", r, k), 32'(rx_q[x0+k]), 32'(vecs[r].bytes[8*k +: 8]));
      end
      for (int i = 0; i < NUM_CS; i++) mask[i] = (cs_low[i] - low0[i]) > 0;
      checkOutput($sformatf("v%0d_cs_mask", r), 32'(mask), 32'(vecs[r].exp_mask));
      checkOutput($sformatf("v%0d_cs_changes", r), cs_changes - c0, vecs[r].exp_changes);
`ifdef SPI_CS_SEQ_ERR_EN
      checkOutput($sformatf("v%0d_err", r), err_cnt - e0, vecs[r].exp_err);
`endif
    end

    // T5: asynchronous reset in the middle of a byte
    applyStimulus(4'd2, 2'd1, 8'h44);
    waitMDv("t5_m_dv");
    tick();
    tick();
    #3 rst_l = 1'b0;
    #1;
    checkOutput("t5_cs_reset", 32'(cs_n), 32'h7);
    checkOutput("t5_ready_reset", 32'(tx_ready), 0);
    checkOutput("t5_m_dv_reset", 32'(m_tx_dv), 0);
    checkOutput("t5_m_byte_reset", 32'(m_tx_byte), 0);
    checkOutput("t5_rx_dv_reset", 32'(rx_dv), 0);
    @(posedge clk);
    #1 rst_l = 1'b1;
    tick();
    checkOutput("t5_ready_after", 32'(tx_ready), 1);
    applyStimulus(4'd1, 2'd1, 8'h5E);
    checkOutput("t5_new_cs_low", 32'(cs_n), 32'h5);
    waitRx("t5_rx");
    checkOutput("t5_rx_byte", 32'(rx_byte), 32'h5E);
    waitReady("t5_idle");

    checkOutput("one_hot_cs", multi_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
